// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
// Imported by the round-robin picker and the arbiter top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int ADDR_W_DEF   = 13;
  localparam int DATA_W_DEF   = 8;
  localparam int WAIT_CYC_DEF = 2;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between the CPU and DMA requesters.
// On a tie the port that did not own the last transaction wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | dma_req;
    grant_id    = OWN_CPU;
    unique case (1'b1)
      (cpu_req && dma_req):  grant_id = ~last_owner;
      (dma_req && !cpu_req): grant_id = OWN_DMA;
      default:               grant_id = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between CPU and DMA ports with round-robin
// grant, a fixed number of strobe cycles and a one-cycle acknowledge.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

  arb_state_t  state;
  logic [3:0]  cnt;
  logic        last_owner;
  logic        grant_valid;
  logic        grant_id;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_rr u_rr (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign sel_we    = grant_id ? dma_we    : cpu_we;
  assign sel_addr  = grant_id ? dma_addr  : cpu_addr;
  assign sel_wdata = grant_id ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_owner <= OWN_DMA;
      owner      <= OWN_CPU;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ACCESS;
            owner      <= grant_id;
            last_owner <= grant_id;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_rd     <= !sel_we;
            mem_wr     <= sel_we;
            busy       <= 1'b1;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            // mem_rd still reflects the latched direction here
            if (mem_rd) begin
              if (owner == OWN_DMA) dma_rdata <= mem_rdata;
              else                  cpu_rdata <= mem_rdata;
            end
            if (owner == OWN_DMA) dma_ack <= 1'b1;
            else                  cpu_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle table plus corner sequences.
// A second instance runs with a single wait cycle.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        cpu_req, cpu_we, cpu_ack, dma_req, dma_we, dma_ack;
  logic [12:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, busy, owner;

  logic        w1_cpu_req, w1_cpu_we, w1_cpu_ack, w1_dma_ack;
  logic [12:0] w1_cpu_addr, w1_mem_addr;
  logic [7:0]  w1_cpu_wdata, w1_cpu_rdata, w1_dma_rdata;
  logic [7:0]  w1_mem_wdata, w1_mem_rdata;
  logic        w1_mem_rd, w1_mem_wr, w1_busy, w1_owner;

  function automatic logic [7:0] rom(input logic [12:0] a);
    case (a)
      13'h0010: rom = 8'hA5;
      13'h0001: rom = 8'h5E;
      13'h0100: rom = 8'hC3;
      default:  rom = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  assign mem_rdata    = rom(mem_addr);
  assign w1_mem_rdata = rom(w1_mem_addr);

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.ADDR_W(13), .DATA_W(8), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr),
    .cpu_wdata(w1_cpu_wdata), .cpu_ack(w1_cpu_ack),
    .cpu_rdata(w1_cpu_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(13'h0),
    .dma_wdata(8'h00), .dma_ack(w1_dma_ack), .dma_rdata(w1_dma_rdata),
    .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
    .mem_rd(w1_mem_rd), .mem_wr(w1_mem_wr), .mem_rdata(w1_mem_rdata),
    .busy(w1_busy), .owner(w1_owner)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [12:0] caddr;
    logic [7:0]  cwd;
    logic        dreq, dwe;
    logic [12:0] daddr;
    logic [7:0]  dwd;
    logic        e_rd, e_wr;
    logic [12:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_cack, e_dack, e_busy, e_own;
    logic [7:0]  e_crd, e_drd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic creq, input logic cwe,
    input logic [12:0] caddr, input logic [7:0] cwd,
    input logic dreq, input logic dwe,
    input logic [12:0] daddr, input logic [7:0] dwd,
    input logic e_rd, input logic e_wr,
    input logic [12:0] e_addr, input logic [7:0] e_wd,
    input logic e_cack, input logic e_dack,
    input logic e_busy, input logic e_own,
    input logic [7:0] e_crd, input logic [7:0] e_drd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_cack = e_cack; v.e_dack = e_dack;
    v.e_busy = e_busy; v.e_own = e_own;
    v.e_crd = e_crd; v.e_drd = e_drd;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    int order[$];
    int stamps[$];
    int ovl, wide, addr_bad, cyc;
    logic pc, pd;
    bit   seen_wr;

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    w1_cpu_req = 0; w1_cpu_we = 0; w1_cpu_addr = '0; w1_cpu_wdata = '0;

    // CPU read 0x10 -> A5
    vt.push_back(mk(0, 1,0,13'h10,8'h0, 0,0,13'h0,8'h0,
                    1,0,13'h10,8'h0, 0,0,1,0, 8'h0,8'h0));
    vt.push_back(mk(0, 1,0,13'h10,8'h0, 0,0,13'h0,8'h0,
                    1,0,13'h10,8'h0, 0,0,1,0, 8'h0,8'h0));
    vt.push_back(mk(0, 1,0,13'h10,8'h0, 0,0,13'h0,8'h0,
                    0,0,13'h10,8'h0, 1,0,1,0, 8'hA5,8'h0));
    vt.push_back(mk(0, 0,0,13'h10,8'h0, 0,0,13'h0,8'h0,
                    0,0,13'h10,8'h0, 0,0,0,0, 8'hA5,8'h0));
    // reset clears everything, including rdata
    vt.push_back(mk(1, 0,0,13'h0,8'h0, 0,0,13'h0,8'h0,
                    0,0,13'h0,8'h0, 0,0,0,0, 8'h0,8'h0));
    // tie: CPU read 0x1 wins, then DMA write 0x2 = 3C
    vt.push_back(mk(0, 1,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    1,0,13'h1,8'h0, 0,0,1,0, 8'h0,8'h0));
    vt.push_back(mk(0, 1,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    1,0,13'h1,8'h0, 0,0,1,0, 8'h0,8'h0));
    vt.push_back(mk(0, 1,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    0,0,13'h1,8'h0, 1,0,1,0, 8'h5E,8'h0));
    vt.push_back(mk(0, 0,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    0,0,13'h1,8'h0, 0,0,0,0, 8'h5E,8'h0));
    vt.push_back(mk(0, 0,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    0,1,13'h2,8'h3C, 0,0,1,1, 8'h5E,8'h0));
    vt.push_back(mk(0, 0,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    0,1,13'h2,8'h3C, 0,0,1,1, 8'h5E,8'h0));
    vt.push_back(mk(0, 0,0,13'h1,8'h0, 1,1,13'h2,8'h3C,
                    0,0,13'h2,8'h3C, 0,1,1,1, 8'h5E,8'h0));
    vt.push_back(mk(0, 0,0,13'h1,8'h0, 0,1,13'h2,8'h3C,
                    0,0,13'h2,8'h3C, 0,0,0,1, 8'h5E,8'h0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rst_acks", 32'({cpu_ack, dma_ack}), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_addr", 32'(mem_addr), 0);

    foreach (vt[i]) begin
      @(negedge clk);
      rst_n = !vt[i].rst;
      cpu_req = vt[i].creq; cpu_we = vt[i].cwe;
      cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
      dma_req = vt[i].dreq; dma_we = vt[i].dwe;
      dma_addr = vt[i].daddr; dma_wdata = vt[i].dwd;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rd", i), 32'(mem_rd), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_wr", i), 32'(mem_wr), 32'(vt[i].e_wr));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].e_wd));
      chk($sformatf("v%0d_cack", i), 32'(cpu_ack), 32'(vt[i].e_cack));
      chk($sformatf("v%0d_dack", i), 32'(dma_ack), 32'(vt[i].e_dack));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vt[i].e_own));
      chk($sformatf("v%0d_crd", i), 32'(cpu_rdata), 32'(vt[i].e_crd));
      chk($sformatf("v%0d_drd", i), 32'(dma_rdata), 32'(vt[i].e_drd));
    end

    // both ports hold requests for six transactions
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h5;
    dma_req = 1; dma_we = 0; dma_addr = 13'h6;
    ovl = 0; wide = 0; pc = 0; pd = 0;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      @(posedge clk);
      #1;
      if (mem_rd && mem_wr) ovl++;
      if (cpu_ack && pc) wide++;
      if (dma_ack && pd) wide++;
      if (cpu_ack) order.push_back(0);
      if (dma_ack) order.push_back(1);
      pc = cpu_ack; pd = dma_ack;
    end
    cpu_req = 0; dma_req = 0;
    chk("alt_count", 32'(order.size()), 6);
    foreach (order[k]) chk($sformatf("alt_order%0d", k), 32'(order[k]), 32'(k % 2));
    chk("alt_ack_width", 32'(wide), 0);
    chk("alt_rdwr_overlap", 32'(ovl), 0);
    chk("alt_crd", 32'(cpu_rdata), 32'h5F);
    chk("alt_drd", 32'(dma_rdata), 32'h5C);

    // DMA address changes after grant
    repeat (2) @(negedge clk);
    dma_req = 1; dma_we = 0; dma_addr = 13'h100;
    @(posedge clk);
    #1;
    chk("hold_granted", 32'({mem_rd, owner}), 32'b11);
    dma_addr = 13'h200;
    addr_bad = 0;
    cyc = 0;
    while (!dma_ack && cyc < 10) begin
      if (mem_addr !== 13'h100) addr_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    dma_req = 0;
    chk("hold_ack_seen", 32'(dma_ack), 1);
    chk("hold_addr_bad", 32'(addr_bad), 0);
    chk("hold_addr_done", 32'(mem_addr), 32'h100);
    chk("hold_drd", 32'(dma_rdata), 32'hC3);

    // reset in the second ACCESS cycle of a CPU write
    repeat (2) @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h40; cpu_wdata = 8'h77;
    @(posedge clk);
    #1;
    chk("mrst_wr1", 32'(mem_wr), 1);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("mrst_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_acks", 32'({cpu_ack, dma_ack}), 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    cpu_req = 0; cpu_we = 0;
    @(negedge clk); rst_n = 1;
    pc = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      pc = pc | cpu_ack;
    end
    chk("mrst_no_ack", 32'(pc), 0);
    @(negedge clk);
    cpu_req = 1; cpu_addr = 13'h7;
    dma_req = 1; dma_addr = 13'h8;
    @(posedge clk);
    #1;
    chk("mrst_tie_cpu", 32'(owner), 0);
    chk("mrst_tie_busy", 32'(busy), 1);
    cyc = 0;
    while (!cpu_ack && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    cpu_req = 0; dma_req = 0;
    chk("mrst_tie_ack", 32'(cpu_ack), 1);

    // single wait cycle: back-to-back reads with a write between
    repeat (3) @(negedge clk);
    w1_cpu_req = 1; w1_cpu_we = 0; w1_cpu_addr = 13'h20;
    seen_wr = 0;
    cyc = 0;
    for (int c = 0; c < 40 && stamps.size() < 4; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (w1_mem_wr) seen_wr = 1;
      if (w1_cpu_ack) begin
        stamps.push_back(cyc);
        if (stamps.size() == 2) begin
          chk("w1_rd1", 32'(w1_cpu_rdata), 32'h7A);
          w1_cpu_we = 1; w1_cpu_addr = 13'h33; w1_cpu_wdata = 8'h11;
        end else if (stamps.size() == 3) begin
          chk("w1_after_wr", 32'(w1_cpu_rdata), 32'h7A);
          w1_cpu_we = 0; w1_cpu_addr = 13'h44;
        end
      end
    end
    w1_cpu_req = 0;
    chk("w1_acks", 32'(stamps.size()), 4);
    for (int k = 1; k < stamps.size(); k++)
      chk($sformatf("w1_period%0d", k), 32'(stamps[k] - stamps[k-1]), 3);
    chk("w1_wr_seen", 32'(seen_wr), 1);
    chk("w1_rd2", 32'(w1_cpu_rdata), 32'h1E);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
